univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop with synchronous reset.
- WIDTH-bit register with eight operating modes: hold, parallel load, logical shift left/right, rotate left/right, up/down count, synchronous clear.
- Serves as the general-purpose storage/shift/count element for datapath and sequencing blocks.
- Gives serial chaining outputs and a terminal-count flag, so instances cascade into wider shifters and counters.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value Q takes on reset; truncated to WIDTH bits.

Ports:
- C  input  1  clock; all state changes on rising edge.
- RE  input  1  reset; synchronous, active-high.
- EN  input  1  clock enable; when 0, Q holds regardless of MODE.
- MODE  input  3  operation select (encoding in Behaviour).
- D  input  WIDTH  parallel load data.
- SI_LSB  input  1  serial in, enters bit 0 on shift left.
- SI_MSB  input  1  serial in, enters bit WIDTH-1 on shift right.
- Q  output  WIDTH  register contents.
- Qnot  output  WIDTH  bitwise complement of Q, always.
- SO_MSB  output  1  equals Q[WIDTH-1] (serial out for left shift chains).
- SO_LSB  output  1  equals Q[0] (serial out for right shift chains).
- TC  output  1  terminal count, combinational (see Behaviour).

Behaviour:
- Edge: rising edge of C only; no asynchronous paths.
- Priority at each edge: RE > EN > MODE.
- RE=1 at an edge: Q <= RESET_VAL. EN and MODE are ignored. Qnot = ~RESET_VAL, SO_MSB/SO_LSB follow Q, TC per rule below.
- RE=0, EN=0: Q holds.
- RE=0, EN=1, MODE:
  - 000 HOLD: Q <= Q.
  - 001 LOAD: Q <= D.
  - 010 SHL: Q <= {Q[W-2:0], SI_LSB}.
  - 011 SHR: Q <= {SI_MSB, Q[W-1:1]}.
  - 100 ROL: Q <= {Q[W-2:0], Q[W-1]}.
  - 101 ROR: Q <= {Q[0], Q[W-1:1]}.
  - 110 CNT: count by one, modulo 2^WIDTH. Direction is selected by D[0]: 1 = up, 0 = down. The remaining D bits are ignored in this mode.
  - 111 CLR: Q <= 0 (not RESET_VAL).
- Count wrap-around: all-ones+1 -> 0; 0-1 -> all-ones; no saturation, no sticky flag.
- TC = 1 only when EN=1, MODE=110, and either (D[0]=1 and Q=all-ones) or (D[0]=0 and Q=0); otherwise 0.
  - TC is combinational from current Q/EN/MODE/D[0], so it can drive the next stage's EN for cascading.
- Latency: Q reflects the operation one edge after sampling. Qnot, SO_*, TC are combinational from Q and inputs, with no extra cycle.
- Simultaneous RE and any mode: reset wins for that edge. Deasserting RE mid-operation resumes from RESET_VAL on the next enabled edge.
- Undriven (X) MODE with EN=1: implementation holds Q. Verification treats it as don't-care.
- Power-up before first reset: Q undefined. A bench must apply RE for at least one edge.

Decomposition:
- Shared package holds:
  - mode constants MODE_HOLD..MODE_CLR (3-bit);
  - count direction constants DIR_DOWN=0, DIR_UP=1.
- One natural sub-module, univ_reg_cell: a one-bit slice.
  - Contains the per-bit next-state mux (hold/load/left-neighbour/right-neighbour/count-sum/zero) and the storage flip-flop with synchronous reset to its RESET_VAL bit.
  - Instantiated WIDTH times by generate loop.
- Count carry/borrow chain lives in the top level and feeds each cell's count input.

Test Plan:
- Reset: RESET_VAL=8'hA5, RE=1 with EN=1, MODE=001, D=8'h3C for one edge -> Q=8'hA5, Qnot=8'h5A. RE=0, same inputs, next edge -> Q=8'h3C.
- Shift chain: load 8'h81, then SHL with SI_LSB=0 for two edges -> Q=8'h04; SO_MSB is 1 before the first shift and 0 after. Then SHR with SI_MSB=1 for three edges -> Q=8'hE0.
- Rotate: load 8'h81, ROL one edge -> 8'h03; ROR two edges -> 8'hC0. Eight ROL edges return the original value.
- Count wrap/TC: load 8'hFE, CNT with D[0]=1. TC=0 at 8'hFE; TC=1 at 8'hFF; next edge -> Q=8'h00, TC=0. Switch D[0]=0: TC=1 at 8'h00; next edge -> Q=8'hFF.
- Enable gating: Q=8'h55, EN=0 with MODE=111 for three edges -> Q stays 8'h55. EN=1 next edge -> Q=8'h00 (not RESET_VAL).
- Mid-operation reset: counting up from 8'h10, assert RE on the edge where Q would become 8'h13 -> Q=RESET_VAL. Release RE with CNT up -> RESET_VAL+1 on the next edge.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift/count register.
// Mode encodings and count direction values.
package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CNT  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/univ_reg_cell.sv
// One-bit slice: next-state mux plus flip-flop with synchronous reset.
// Neighbour and count inputs are resolved by the parent.
module univ_reg_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [2:0] i_mode,
    input  logic       i_d,
    input  logic       i_lin,
    input  logic       i_rin,
    input  logic       i_cnt,
    output logic       o_q
);

    logic r_q;
    logic w_nxt;

    // Unknown mode values fall through to hold.
    always_comb begin
        w_nxt = r_q;
        case (i_mode)
            MODE_HOLD: w_nxt = r_q;
            MODE_LOAD: w_nxt = i_d;
            MODE_SHL:  w_nxt = i_lin;
            MODE_ROL:  w_nxt = i_lin;
            MODE_SHR:  w_nxt = i_rin;
            MODE_ROR:  w_nxt = i_rin;
            MODE_CNT:  w_nxt = i_cnt;
            MODE_CLR:  w_nxt = 1'b0;
            default:   w_nxt = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_BIT;
        end else if (i_en) begin
            r_q <= w_nxt;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load, shift, rotate, count, clear.
// Serial and terminal-count outputs allow cascading instances.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic             C,
    input  logic             RE,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_LSB,
    input  logic             SI_MSB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             SO_MSB,
    output logic             SO_LSB,
    output logic             TC
);

    localparam logic [WIDTH-1:0] RV = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_lin;
    logic [WIDTH-1:0] w_rin;
    logic [WIDTH-1:0] w_match;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_cnt;

    // A bit toggles when every lower bit already sits at the wrap value
    // for the chosen direction: all ones counting up, all zeros down.
    assign w_match = (D[0] == DIR_UP) ? w_q : ~w_q;
    assign w_cnt   = w_q ^ w_tog;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lo
            assign w_lin[i] = (MODE == MODE_ROL) ? w_q[WIDTH-1] : SI_LSB;
            assign w_tog[i] = 1'b1;
        end else begin : g_hi
            assign w_lin[i] = w_q[i-1];
            assign w_tog[i] = &w_match[i-1:0];
        end

        if (i == WIDTH - 1) begin : g_top
            assign w_rin[i] = (MODE == MODE_ROR) ? w_q[0] : SI_MSB;
        end else begin : g_mid
            assign w_rin[i] = w_q[i+1];
        end

        univ_reg_cell #(
            .RST_BIT (RV[i])
        ) u_cell (
            .i_clk  (C),
            .i_rst  (RE),
            .i_en   (EN),
            .i_mode (MODE),
            .i_d    (D[i]),
            .i_lin  (w_lin[i]),
            .i_rin  (w_rin[i]),
            .i_cnt  (w_cnt[i]),
            .o_q    (w_q[i])
        );
    end

    assign Q      = w_q;
    assign Qnot   = ~w_q;
    assign SO_MSB = w_q[WIDTH-1];
    assign SO_LSB = w_q[0];
    assign TC     = EN & (MODE == MODE_CNT) & (&w_match);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Expected Q values are queued at drive time and popped after each edge.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic       C = 1'b0;
    logic       RE, EN, SI_LSB, SI_MSB;
    logic [2:0] MODE;
    logic [7:0] D;
    logic [7:0] Q, Qnot;
    logic       SO_MSB, SO_LSB, TC;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q;
    logic [7:0] sb[$];
    logic [7:0] exp_q;

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (32'hA5)
    ) dut (
        .C      (C),
        .RE     (RE),
        .EN     (EN),
        .MODE   (MODE),
        .D      (D),
        .SI_LSB (SI_LSB),
        .SI_MSB (SI_MSB),
        .Q      (Q),
        .Qnot   (Qnot),
        .SO_MSB (SO_MSB),
        .SO_LSB (SO_LSB),
        .TC     (TC)
    );

    always #5 C = ~C;

    function automatic logic [7:0] model(
        input logic [7:0] q, input logic re, input logic en,
        input logic [2:0] mode, input logic [7:0] d,
        input logic sil, input logic sim);
        if (re) return 8'hA5;
        if (!en) return q;
        case (mode)
            3'd0: return q;
            3'd1: return d;
            3'd2: return {q[6:0], sil};
            3'd3: return {sim, q[7:1]};
            3'd4: return {q[6:0], q[7]};
            3'd5: return {q[0], q[7:1]};
            3'd6: return d[0] ? q + 8'd1 : q - 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive(input logic re, input logic en,
                         input logic [2:0] mode, input logic [7:0] d,
                         input logic sil, input logic sim);
        RE = re; EN = en; MODE = mode; D = d;
        SI_LSB = sil; SI_MSB = sim;
        m_q = model(m_q, re, en, mode, d, sil, sim);
        sb.push_back(m_q);
    endtask

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'hA5) begin
            failures++;
            $display("FAIL reset_q got=%h exp=%h", Q, exp_q);
        end
        checks++;
        if (Qnot !== 8'h5A) begin
            failures++;
            $display("FAIL reset_qnot got=%h exp=5a", Qnot);
        end
        drive(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'h3C) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", Q, exp_q);
        end
    endtask

    task automatic test_shift;
        drive(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || SO_MSB !== 1'b1) begin
            failures++;
            $display("FAIL shift_load got=%h/%b exp=%h/1", Q, SO_MSB, exp_q);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || SO_MSB !== 1'b0) begin
                failures++;
                $display("FAIL shl%0d got=%h/%b exp=%h/0", i, Q, SO_MSB, exp_q);
            end
        end
        checks++;
        if (Q !== 8'h04) begin
            failures++;
            $display("FAIL shl_final got=%h exp=04", Q);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || SO_LSB !== exp_q[0]) begin
                failures++;
                $display("FAIL shr%0d got=%h/%b exp=%h", i, Q, SO_LSB, exp_q);
            end
        end
        checks++;
        if (Q !== 8'hE0) begin
            failures++;
            $display("FAIL shr_final got=%h exp=e0", Q);
        end
    endtask

    task automatic test_rotate;
        drive(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        tick();
        void'(sb.pop_front());
        drive(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'h03) begin
            failures++;
            $display("FAIL rol1 got=%h exp=03", Q);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b1, 1'b0);
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q) begin
                failures++;
                $display("FAIL ror%0d got=%h exp=%h", i, Q, exp_q);
            end
        end
        checks++;
        if (Q !== 8'hC0) begin
            failures++;
            $display("FAIL ror_final got=%h exp=c0", Q);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b1, 1'b0);
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q) begin
                failures++;
                $display("FAIL rol8_%0d got=%h exp=%h", i, Q, exp_q);
            end
        end
        checks++;
        if (Q !== 8'hC0) begin
            failures++;
            $display("FAIL rol8_final got=%h exp=c0", Q);
        end
    endtask

    task automatic test_count;
        drive(1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0);
        tick();
        void'(sb.pop_front());
        drive(1'b0, 1'b1, MODE_CNT, 8'h01, 1'b0, 1'b0);
        #1;
        checks++;
        if (TC !== 1'b0) begin
            failures++;
            $display("FAIL tc_fe got=%b exp=0", TC);
        end
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || TC !== 1'b1) begin
            failures++;
            $display("FAIL cnt_ff got=%h/%b exp=%h/1", Q, TC, exp_q);
        end
        drive(1'b0, 1'b1, MODE_CNT, 8'h01, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'h00 || TC !== 1'b0) begin
            failures++;
            $display("FAIL cnt_wrap got=%h/%b exp=00/0", Q, TC);
        end
        drive(1'b0, 1'b1, MODE_CNT, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if (TC !== 1'b1) begin
            failures++;
            $display("FAIL tc_down got=%b exp=1", TC);
        end
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'hFF) begin
            failures++;
            $display("FAIL cnt_down_wrap got=%h exp=ff", Q);
        end
    endtask

    task automatic test_enable;
        drive(1'b0, 1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, MODE_CLR, 8'h00, 1'b0, 1'b0);
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || Q !== 8'h55) begin
                failures++;
                $display("FAIL en_hold%0d got=%h exp=55", i, Q);
            end
        end
        drive(1'b0, 1'b1, MODE_CLR, 8'h00, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'h00) begin
            failures++;
            $display("FAIL clr got=%h exp=00", Q);
        end
    endtask

    task automatic test_mid_reset;
        drive(1'b0, 1'b1, MODE_LOAD, 8'h10, 1'b0, 1'b0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, MODE_CNT, 8'h01, 1'b0, 1'b0);
            tick();
            void'(sb.pop_front());
        end
        drive(1'b1, 1'b1, MODE_CNT, 8'h01, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'hA5) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=a5", Q);
        end
        drive(1'b0, 1'b1, MODE_CNT, 8'h01, 1'b0, 1'b0);
        tick();
        exp_q = sb.pop_front();
        checks++;
        if (Q !== exp_q || Q !== 8'hA6) begin
            failures++;
            $display("FAIL mid_resume got=%h exp=a6", Q);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] md;
        logic [7:0] dd;
        logic       en, exp_tc;
        for (int i = 0; i < 60; i++) begin
            md = 3'($urandom_range(0, 7));
            dd = 8'($urandom);
            en = ($urandom_range(0, 3) != 0);
            exp_tc = en && (md == 3'd6) &&
                     ((dd[0] && m_q == 8'hFF) || (!dd[0] && m_q == 8'h00));
            drive(1'b0, en, md, dd, 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (TC !== exp_tc) begin
                failures++;
                $display("FAIL b2b_tc%0d got=%b exp=%b", i, TC, exp_tc);
            end
            tick();
            exp_q = sb.pop_front();
            checks++;
            if (Q !== exp_q || Qnot !== ~exp_q) begin
                failures++;
                $display("FAIL b2b_q%0d got=%h/%h exp=%h", i, Q, Qnot, exp_q);
            end
        end
    endtask

    initial begin
        RE = 1'b0; EN = 1'b0; MODE = MODE_HOLD; D = 8'h00;
        SI_LSB = 1'b0; SI_MSB = 1'b0;
        m_q = 8'hxx;
        tick();
        test_reset();
        test_shift();
        test_rotate();
        test_count();
        test_enable();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
